// File: rtl/spi_bridge_pkg.sv
// Shared types and constants for the SPI-to-register-bus bridge.
package spi_bridge_pkg;

   localparam int ERR_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      CMD,
      WR_DATA,
      RD_DATA
   } state_t;

   // Read/not-write flag lives in the top bit of the command frame.
   function automatic int rnw_bit(input int data_w);
      return data_w - 1;
   endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Synchronises the asynchronous SPI pins into clk and flags sclk/cs edges.
module spi_edge_sync #(
   parameter int SYNC_STAGES = 2,
   parameter bit SCLK_IDLE   = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sclk,
   input  logic cs,
   input  logic mosi,
   output logic sclk_rise,
   output logic sclk_fall,
   output logic cs_rise,
   output logic cs_fall,
   output logic mosi_s
);

   logic [SYNC_STAGES-1:0] sclk_sync;
   logic [SYNC_STAGES-1:0] cs_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic                   sclk_prev;
   logic                   cs_prev;

   // Chains reset to the idle pin levels so leaving reset never fakes an edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync <= {SYNC_STAGES{SCLK_IDLE}};
         cs_sync   <= '1;
         mosi_sync <= '0;
         sclk_prev <= SCLK_IDLE;
         cs_prev   <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
         sclk_prev <= sclk_sync[SYNC_STAGES-1];
         cs_prev   <= cs_sync[SYNC_STAGES-1];
      end
   end

   assign sclk_rise = sclk_sync[SYNC_STAGES-1] & ~sclk_prev;
   assign sclk_fall = ~sclk_sync[SYNC_STAGES-1] & sclk_prev;
   assign cs_rise   = cs_sync[SYNC_STAGES-1] & ~cs_prev;
   assign cs_fall   = ~cs_sync[SYNC_STAGES-1] & cs_prev;
   assign mosi_s    = mosi_sync[SYNC_STAGES-1];

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI slave that turns a command frame plus burst data frames into
// register-bus reads and writes with address auto-increment.
module spi_reg_bridge
   import spi_bridge_pkg::*;
#(
   parameter int              DATA_W      = 8,
   parameter int              ADDR_W      = 7,
   parameter bit              CPOL        = 1'b0,
   parameter bit              CPHA        = 1'b0,
   parameter int              SYNC_STAGES = 2,
   parameter logic [DATA_W-1:0] STATUS_WORD = DATA_W'(8'hA5)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              spi_sclk,
   input  logic              spi_cs,
   input  logic              spi_mosi,
   output logic              spi_miso,
   output logic              spi_miso_oe,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [DATA_W-1:0] reg_wdata,
   output logic              reg_wr,
   output logic              reg_rd,
   input  logic [DATA_W-1:0] reg_rdata,
   output logic              busy,
   output logic              frame_err,
   output logic [ERR_W-1:0]  err_count
);

   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam int RNW   = rnw_bit(DATA_W);

   logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s;

   spi_edge_sync #(
      .SYNC_STAGES (SYNC_STAGES),
      .SCLK_IDLE   (CPOL)
   ) u_sync (
      .clk       (clk),
      .rst_n     (rst_n),
      .sclk      (spi_sclk),
      .cs        (spi_cs),
      .mosi      (spi_mosi),
      .sclk_rise (sclk_rise),
      .sclk_fall (sclk_fall),
      .cs_rise   (cs_rise),
      .cs_fall   (cs_fall),
      .mosi_s    (mosi_s)
   );

   logic lead_edge, trail_edge, sample_edge, shift_edge;

   assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
   assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
   assign sample_edge = CPHA ? trail_edge : lead_edge;
   assign shift_edge  = CPHA ? lead_edge : trail_edge;

   state_t            state;
   logic [CNT_W-1:0]  bit_cnt;
   logic [DATA_W-1:0] rx_shift;
   logic [DATA_W-1:0] tx_shift;
   logic [DATA_W-1:0] rx_word;
   logic              rd_wait;
   logic              frame_done;

   assign rx_word    = {rx_shift[DATA_W-2:0], mosi_s};
   assign frame_done = (state != IDLE) && sample_edge &&
                       (bit_cnt == CNT_W'(DATA_W - 1));

   assign busy        = (state != IDLE);
   assign spi_miso_oe = busy;
   assign spi_miso    = busy & tx_shift[DATA_W-1];

   // The shift edge at bit 0 is skipped in both phases: the MSB is already
   // on miso from the load, so shifting there would drop it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         rx_shift  <= '0;
         tx_shift  <= '0;
         rd_wait   <= 1'b0;
         reg_addr  <= '0;
         reg_wdata <= '0;
         reg_wr    <= 1'b0;
         reg_rd    <= 1'b0;
         frame_err <= 1'b0;
         err_count <= '0;
      end else begin
         reg_wr    <= 1'b0;
         reg_rd    <= 1'b0;
         frame_err <= 1'b0;
         rd_wait   <= reg_rd;

         if (reg_wr)
            reg_addr <= reg_addr + ADDR_W'(1);

         if (state == IDLE) begin
            if (cs_fall) begin
               state    <= CMD;
               bit_cnt  <= '0;
               rx_shift <= '0;
               tx_shift <= STATUS_WORD;
            end
         end else begin
            if (sample_edge) begin
               rx_shift <= rx_word;
               bit_cnt  <= frame_done ? '0 : bit_cnt + CNT_W'(1);
            end

            if (shift_edge && (bit_cnt != '0))
               tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};

            if (frame_done) begin
               if (state == CMD) begin
                  reg_addr <= rx_word[ADDR_W-1:0];
                  if (rx_word[RNW]) begin
                     state  <= RD_DATA;
                     reg_rd <= 1'b1;
                  end else begin
                     state <= WR_DATA;
                  end
               end else if (state == WR_DATA) begin
                  reg_wr    <= 1'b1;
                  reg_wdata <= rx_word;
               end else begin
                  reg_addr <= reg_addr + ADDR_W'(1);
                  reg_rd   <= 1'b1;
               end
            end

            if (rd_wait && (state == RD_DATA))
               tx_shift <= reg_rdata;

            // A frame finishing in the same cycle as cs rise still counts.
            if (cs_rise) begin
               state    <= IDLE;
               bit_cnt  <= '0;
               rx_shift <= '0;
               tx_shift <= '0;
               if (!frame_done && (bit_cnt != '0)) begin
                  frame_err <= 1'b1;
                  if (err_count != {ERR_W{1'b1}})
                     err_count <= err_count + ERR_W'(1);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench: one bridge per SPI mode, a small register-file model and
// a strobe monitor, driven by a bit-banged SPI master.
module tb_spi_reg_bridge;

   localparam int HALF = 80;

   typedef struct packed {
      logic [1:0] inst;
      logic [6:0] addr;
      logic [7:0] data;
   } xact_t;

   logic       clk;
   logic       rst_n;
   logic [3:0] sclk;
   logic [3:0] cs;
   logic [3:0] mosi;
   logic [3:0] miso;
   logic [3:0] miso_oe;
   logic [3:0] reg_wr;
   logic [3:0] reg_rd;
   logic [3:0] busy;
   logic [3:0] frame_err;
   logic [6:0] reg_addr  [4];
   logic [7:0] reg_wdata [4];
   logic [7:0] reg_rdata [4];
   logic [7:0] err_count [4];

   xact_t wr_q[$];
   xact_t rd_q[$];
   int    ferr_cnt [4] = '{default: 0};
   int    both_cnt = 0;
   int    tests = 0;
   int    fails = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      spi_reg_bridge #(
         .CPOL (g >= 2),
         .CPHA ((g % 2) == 1)
      ) dut (
         .clk         (clk),
         .rst_n       (rst_n),
         .spi_sclk    (sclk[g]),
         .spi_cs      (cs[g]),
         .spi_mosi    (mosi[g]),
         .spi_miso    (miso[g]),
         .spi_miso_oe (miso_oe[g]),
         .reg_addr    (reg_addr[g]),
         .reg_wdata   (reg_wdata[g]),
         .reg_wr      (reg_wr[g]),
         .reg_rd      (reg_rd[g]),
         .reg_rdata   (reg_rdata[g]),
         .busy        (busy[g]),
         .frame_err   (frame_err[g]),
         .err_count   (err_count[g])
      );
   end

   // Register file answers every read with addr + 0x40 one cycle later.
   always @(posedge clk) begin
      for (int i = 0; i < 4; i++)
         if (reg_rd[i])
            reg_rdata[i] <= 8'h40 + {1'b0, reg_addr[i]};
   end

   // Record every strobe and error pulse away from the active edge.
   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (reg_wr[i]) wr_q.push_back({2'(i), reg_addr[i], reg_wdata[i]});
         if (reg_rd[i]) rd_q.push_back({2'(i), reg_addr[i], 8'h00});
         if (frame_err[i]) ferr_cnt[i]++;
         if (reg_wr[i] && reg_rd[i]) both_cnt++;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
      end
   endtask

   task automatic shiftFrame(input int m, input logic [7:0] d, input int nbits,
                             output logic [7:0] r);
      logic cpol, cpha;
      cpol = (m / 2) != 0;
      cpha = (m % 2) != 0;
      r = '0;
      for (int i = 7; i > 7 - nbits; i--) begin
         if (!cpha) begin
            mosi[m] = d[i];
            #(HALF);
            r[i] = miso[m];
            sclk[m] = ~cpol;
            #(HALF);
            sclk[m] = cpol;
         end else begin
            #(HALF);
            sclk[m] = ~cpol;
            mosi[m] = d[i];
            #(HALF);
            r[i] = miso[m];
            sclk[m] = cpol;
         end
      end
   endtask

   // Frames are packed MSB-first in tx/rx; last_bits > 0 truncates the last frame.
   task automatic applyStimulus(input int m, input int nframes, input logic [31:0] tx,
                                input int last_bits, output logic [31:0] rx);
      logic [7:0] r;
      rx = '0;
      @(negedge clk);
      cs[m] = 1'b0;
      #(HALF);
      for (int k = 0; k < nframes; k++) begin
         shiftFrame(m, tx[31-8*k -: 8],
                    ((k == nframes - 1) && (last_bits > 0)) ? last_bits : 8, r);
         rx[31-8*k -: 8] = r;
      end
      #(HALF);
      cs[m] = 1'b1;
      repeat (10) @(negedge clk);
   endtask

   task automatic expectWrite(input string tag, input int m, input logic [6:0] a,
                              input logic [7:0] d);
      xact_t x;
      x = (wr_q.size() != 0) ? wr_q.pop_front() : '1;
      checkOutput(tag, {15'd0, x}, {15'd0, 2'(m), a, d});
   endtask

   task automatic expectRead(input string tag, input int m, input logic [6:0] a);
      xact_t x;
      x = (rd_q.size() != 0) ? rd_q.pop_front() : '1;
      checkOutput(tag, {15'd0, x.inst, x.addr}, {15'd0, 2'(m), a});
   endtask

   task automatic checkIdle(input string tag, input int m, input logic [7:0] errs);
      checkOutput({tag, "_ctrl"},
                  {26'd0, busy[m], miso[m], miso_oe[m], reg_wr[m], reg_rd[m], frame_err[m]},
                  32'd0);
      checkOutput({tag, "_addr_wdata"}, {17'd0, reg_addr[m], reg_wdata[m]}, 32'd0);
      checkOutput({tag, "_errcnt"}, {24'd0, err_count[m]}, {24'd0, errs});
   endtask

   task automatic writeBurst(input int m);
      logic [31:0] rx;
      wr_q.delete();
      rd_q.delete();
      applyStimulus(m, 4, 32'h10112233, 0, rx);
      checkOutput($sformatf("m%0d_status", m), {24'd0, rx[31:24]}, 32'hA5);
      checkOutput($sformatf("m%0d_wr_count", m), wr_q.size(), 3);
      expectWrite($sformatf("m%0d_wr0", m), m, 7'h10, 8'h11);
      expectWrite($sformatf("m%0d_wr1", m), m, 7'h11, 8'h22);
      expectWrite($sformatf("m%0d_wr2", m), m, 7'h12, 8'h33);
      checkOutput($sformatf("m%0d_no_rd", m), rd_q.size(), 0);
      checkOutput($sformatf("m%0d_ferr", m), ferr_cnt[m], 0);
   endtask

   initial begin
      logic [31:0] rx;
      logic [7:0]  r;

      rst_n = 1'b0;
      cs    = 4'hF;
      sclk  = 4'b1100;
      mosi  = 4'h0;
      repeat (3) @(negedge clk);
      for (int m = 0; m < 4; m++) checkIdle($sformatf("rst_m%0d", m), m, 8'd0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      for (int m = 0; m < 4; m++) checkIdle($sformatf("post_rst_m%0d", m), m, 8'd0);

      for (int m = 0; m < 4; m++) writeBurst(m);

      wr_q.delete();
      rd_q.delete();
      applyStimulus(0, 3, 32'h85000000, 0, rx);
      checkOutput("m0_rd_status", {24'd0, rx[31:24]}, 32'hA5);
      checkOutput("m0_rd_data0", {24'd0, rx[23:16]}, 32'h45);
      checkOutput("m0_rd_data1", {24'd0, rx[15:8]}, 32'h46);
      checkOutput("m0_rd_count", rd_q.size(), 3);
      expectRead("m0_rd_a5", 0, 7'h05);
      expectRead("m0_rd_a6", 0, 7'h06);
      expectRead("m0_rd_a7", 0, 7'h07);
      checkOutput("m0_rd_no_wr", wr_q.size(), 0);

      wr_q.delete();
      rd_q.delete();
      applyStimulus(3, 3, 32'h85000000, 0, rx);
      checkOutput("m3_rd_status", {24'd0, rx[31:24]}, 32'hA5);
      checkOutput("m3_rd_data0", {24'd0, rx[23:16]}, 32'h45);
      checkOutput("m3_rd_data1", {24'd0, rx[15:8]}, 32'h46);
      checkOutput("m3_rd_count", rd_q.size(), 3);

      wr_q.delete();
      rd_q.delete();
      applyStimulus(0, 3, 32'h7FAABB00, 0, rx);
      checkOutput("wrap_count", wr_q.size(), 2);
      expectWrite("wrap_7f", 0, 7'h7F, 8'hAA);
      expectWrite("wrap_00", 0, 7'h00, 8'hBB);

      wr_q.delete();
      applyStimulus(0, 3, 32'h205AC300, 5, rx);
      checkOutput("abort_wr_count", wr_q.size(), 1);
      expectWrite("abort_wr0", 0, 7'h20, 8'h5A);
      checkOutput("abort_ferr", ferr_cnt[0], 1);
      checkOutput("abort_errcnt", {24'd0, err_count[0]}, 32'd1);
      wr_q.delete();
      applyStimulus(0, 2, 32'h30770000, 0, rx);
      checkOutput("after_abort_count", wr_q.size(), 1);
      expectWrite("after_abort_wr", 0, 7'h30, 8'h77);
      checkOutput("after_abort_ferr", ferr_cnt[0], 1);
      checkOutput("after_abort_errcnt", {24'd0, err_count[0]}, 32'd1);

      @(negedge clk);
      cs[0] = 1'b0;
      #(HALF);
      shiftFrame(0, 8'h85, 8, r);
      shiftFrame(0, 8'h00, 3, r);
      checkOutput("midrd_busy", {31'd0, busy[0]}, 32'd1);
      rst_n = 1'b0;
      #1;
      wr_q.delete();
      rd_q.delete();
      repeat (3) @(negedge clk);
      checkIdle("midrd_rst", 0, 8'd0);
      cs[0] = 1'b1;
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      checkOutput("midrd_busy_after", {31'd0, busy[0]}, 32'd0);
      checkOutput("midrd_no_strobes", wr_q.size() + rd_q.size(), 0);
      applyStimulus(0, 2, 32'h83000000, 0, rx);
      checkOutput("midrd_next_status", {24'd0, rx[31:24]}, 32'hA5);
      checkOutput("midrd_next_data", {24'd0, rx[23:16]}, 32'h43);
      checkOutput("midrd_next_rd_count", rd_q.size(), 2);
      expectRead("midrd_next_a3", 0, 7'h03);
      expectRead("midrd_next_a4", 0, 7'h04);

      checkOutput("wr_rd_overlap", both_cnt, 0);
      for (int m = 1; m < 4; m++)
         checkOutput($sformatf("m%0d_errcnt_end", m), {24'd0, err_count[m]}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/spi_reg_bridge.md
Name: spi_reg_bridge

Overview:
- Parametrised SPI slave that bridges an external SPI master onto the shared register-file bus, the same bus the I2C slave drives (reg_addr/reg_wdata/reg_wr/reg_rd/reg_rdata).
- Supports all four SPI modes and configurable frame width.
- Transactions are a command frame followed by burst data frames with address auto-increment.
- Successor to the single-byte spi_slave: adds a register read/write protocol, mode selection and framing-error detection.

Parameters:
- DATA_W, 8: bits per SPI frame and register data width.
- ADDR_W, 7: register address width; must be ≤ DATA_W-1.
- CPOL, 0: SCLK idle level.
- CPHA, 0: 0 = sample on the leading edge, 1 = sample on the trailing edge.
- SYNC_STAGES, 2: synchroniser depth for sclk, cs, mosi; minimum 2.
- STATUS_WORD, 8'hA5: value shifted out on MISO during the command frame.

Ports:
- clk  in  1  system clock; must run at ≥ 8× fsclk.
- rst_n  in  1  asynchronous active-low reset.
- spi_sclk  in  1  SPI clock (asynchronous).
- spi_cs  in  1  chip select, active low (asynchronous).
- spi_mosi  in  1  master-out data.
- spi_miso  out  1  slave-out data.
- spi_miso_oe  out  1  high while cs is asserted; the top level tristates on this.
- reg_addr  out  ADDR_W  register address.
- reg_wdata  out  DATA_W  register write data.
- reg_wr  out  1  one-cycle write strobe.
- reg_rd  out  1  one-cycle read strobe.
- reg_rdata  in  DATA_W  read data, valid the cycle after reg_rd.
- busy  out  1  transaction in progress.
- frame_err  out  1  one-cycle pulse on an aborted partial frame.
- err_count  out  8  saturating count of framing errors.

Behaviour:
- Reset values: all outputs 0, state IDLE, shift registers 0, err_count 0. Reset mid-transaction abandons the transaction with no strobes issued.
- Synchronisation: sclk, cs and mosi pass through SYNC_STAGES flops. Edges are detected in the clk domain. mosi is taken from the same synchroniser depth as sclk.
- Edge mapping:
  - leading edge = rising if CPOL=0, else falling.
  - sample edge = leading if CPHA=0, else trailing.
  - shift edge = the other edge.
- Data order: MSB first in both directions. Bit counter 0..DATA_W-1; a frame completes on the DATA_W-th sample edge.
- Command frame: bit DATA_W-1 = rnw (1 = read); bits ADDR_W-1:0 = start address. Remaining bits ignored.
- State machine: IDLE, CMD, WR_DATA, RD_DATA.
  - IDLE → CMD on cs fall. tx shift loads STATUS_WORD; with CPHA=0 its MSB appears on miso the cycle after the cs fall is detected.
  - CMD → WR_DATA on frame complete with rnw=0: latch address.
  - CMD → RD_DATA on frame complete with rnw=1: latch address, pulse reg_rd the next cycle, capture reg_rdata one cycle later into the tx shift register.
  - WR_DATA, each frame complete: reg_wdata = received word, reg_addr = current address, reg_wr pulses 1 cycle (latency ≤ 2 clk after the final sample edge), then address += 1.
  - RD_DATA, on each frame complete: address += 1, reg_rd pulses for the new address, reg_rdata is loaded into the tx shift register before the next frame's first shift edge.
  - Any state → IDLE on cs rise.
- Address wrap: increments modulo 2^ADDR_W (max address → 0).
- cs rise mid-frame (bit counter ≠ 0): partial frame is discarded, no reg_wr, frame_err pulses 1 cycle, err_count increments and saturates at 255. cs rise on a frame boundary is not an error.
- A cs rise and a frame complete in the same clk: the frame completes first (strobe issued), then the bridge returns to IDLE.
- spi_miso drives 0 and spi_miso_oe is 0 whenever cs is deasserted.
- busy = (state ≠ IDLE).
- reg_wr and reg_rd are never asserted in the same cycle.

Decomposition:
- Package spi_bridge_pkg holds: state enum (IDLE, CMD, WR_DATA, RD_DATA), the rnw bit index function, and the err_count width constant.
- One sub-module, spi_edge_sync: synchroniser plus rise/fall detection for sclk/cs/mosi, parameterised by SYNC_STAGES.

Test Plan:
- Mode 0 write burst: cmd 0x10, data 0x11, 0x22, 0x33 → reg_wr ×3 at addr 0x10/0x11/0x12 with data 0x11/0x22/0x33; frame_err stays 0.
- Mode 0 read burst: cmd 0x85 with regfile model returning addr+0x40 → MISO shows 0xA5, then 0x45, 0x46; reg_rd pulses for addrs 5 and 6 (and 7 as prefetch).
- Modes 1, 2, 3: repeat the write-burst scenario with a matching master → identical reg_wr sequence.
- Wrap-around: write cmd 0x7F, two data words → writes to 0x7F then 0x00.
- Abort: cs rises after 5 bits of the second data frame → one reg_wr only, frame_err pulses once, err_count = 1; the following transaction works normally.
- Reset mid-read (rst_n low for 3 clk during RD_DATA) → all outputs 0, busy 0, no strobes; the next transaction succeeds.
